// File: rtl/frame_writer.sv
// Packs an 8-bit pixel stream into 32-bit words, buffers them and issues
// single-word SDRAM writes on a linear, wrapping frame address.
module frame_writer #(
  parameter int          FRAME_WORDS = 96000,
  parameter logic [21:0] BASE_ADDR   = 22'd0,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [1:0]  CMD_NOP     = 2'd0,
  parameter logic [1:0]  CMD_WRITE   = 2'd2
) (
  input  logic        i_Clk,
  input  logic        i_Rst_N,
  input  logic        i_Begin,
  input  logic [7:0]  i_Pixel,
  input  logic        i_Pixel_Valid,
  input  logic        i_Frame_Start,
  output logic        o_Pixel_Ready,
  input  logic        i_Data_Write_Done,
  output logic [1:0]  o_Command,
  output logic [21:0] o_Data_Address,
  output logic [31:0] o_Data_Write,
  output logic        o_Frame_Done,
  output logic        o_Busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [21:0]      LAST_ADDR = BASE_ADDR + 22'(FRAME_WORDS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE} state_t;
  state_t state;

  logic [1:0]       byte_cnt;
  logic [23:0]      pack_bytes;
  logic             pack_tag;
  logic [32:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;
  logic [CNT_W-1:0] fifo_cnt;
  logic [CNT_W-1:0] fifo_cnt_next;
  logic             not_full_q;
  logic [21:0]      wr_ptr;

  logic        xfer;
  logic        push;
  logic        pop;
  logic [1:0]  eff_cnt;
  logic        word_tag;
  logic [32:0] push_entry;
  logic [32:0] head;

  // Handshake: a pixel moves on a rising edge where i_Pixel_Valid and
  // o_Pixel_Ready are both high; neither side may make valid depend on ready.
  always_comb begin
    xfer       = i_Pixel_Valid && o_Pixel_Ready;
    // A frame-start pixel restarts the group, dropping any partial bytes.
    eff_cnt    = i_Frame_Start ? 2'd0 : byte_cnt;
    word_tag   = i_Frame_Start || ((eff_cnt != 2'd0) && pack_tag);
    push       = xfer && (eff_cnt == 2'd3);
    pop        = (state == S_WAIT) && (fifo_cnt != '0);
    push_entry = {word_tag, i_Pixel, pack_bytes};
    head       = fifo_mem[rd_idx];
    fifo_cnt_next = fifo_cnt;
    if (push && !pop)      fifo_cnt_next = fifo_cnt + 1'b1;
    else if (!push && pop) fifo_cnt_next = fifo_cnt - 1'b1;
  end

  assign o_Pixel_Ready = i_Begin && not_full_q;
  assign o_Busy        = (fifo_cnt != '0) || (byte_cnt != 2'd0) || (state == S_WRITE);

  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      byte_cnt   <= 2'd0;
      pack_bytes <= 24'd0;
      pack_tag   <= 1'b0;
    end else if (xfer) begin
      if (eff_cnt == 2'd3) begin
        byte_cnt <= 2'd0;
      end else begin
        byte_cnt <= eff_cnt + 2'd1;
        pack_tag <= word_tag;
        case (eff_cnt)
          2'd0:    pack_bytes[7:0]   <= i_Pixel;
          2'd1:    pack_bytes[15:8]  <= i_Pixel;
          default: pack_bytes[23:16] <= i_Pixel;
        endcase
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (push) fifo_mem[wr_idx] <= push_entry;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      wr_idx     <= '0;
      rd_idx     <= '0;
      fifo_cnt   <= '0;
      not_full_q <= 1'b0;
    end else begin
      if (push) wr_idx <= wr_idx + 1'b1;
      if (pop)  rd_idx <= rd_idx + 1'b1;
      fifo_cnt   <= fifo_cnt_next;
      not_full_q <= (fifo_cnt_next != FULL_CNT);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      state          <= S_IDLE;
      o_Command      <= CMD_NOP;
      o_Data_Address <= BASE_ADDR;
      o_Data_Write   <= 32'd0;
      o_Frame_Done   <= 1'b0;
      wr_ptr         <= BASE_ADDR;
    end else begin
      o_Frame_Done <= 1'b0;
      case (state)
        S_IDLE: begin
          o_Command <= CMD_NOP;
          if (i_Begin) state <= S_WAIT;
        end
        S_WAIT: begin
          if (pop) begin
            o_Data_Write   <= head[31:0];
            o_Data_Address <= head[32] ? BASE_ADDR : wr_ptr;
            o_Command      <= CMD_WRITE;
            state          <= S_WRITE;
          end else if (!i_Begin) begin
            state <= S_IDLE;
          end
        end
        S_WRITE: begin
          if (i_Data_Write_Done) begin
            o_Command <= CMD_NOP;
            state     <= S_WAIT;
            if (o_Data_Address == LAST_ADDR) begin
              wr_ptr       <= BASE_ADDR;
              o_Frame_Done <= 1'b1;
            end else begin
              wr_ptr <= o_Data_Address + 22'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer with a small frame (4 words) so the
// address wrap and frame-done pulse are reachable quickly.
module tb_frame_writer;

  localparam logic [1:0] CMD_NOP   = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        begin_en = 1'b0;
  logic [7:0]  pix = 8'd0;
  logic        pix_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic        ready;
  logic        done = 1'b0;
  logic [1:0]  cmd;
  logic [21:0] addr;
  logic [31:0] wdata;
  logic        frame_done;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int sent     = 0;
  int fd_cnt   = 0;

  logic [53:0] exp_q[$];

  // Controller model state
  int          done_delay = 3;
  logic        done_en = 1'b1;
  logic        active = 1'b0;
  logic        done_sent = 1'b0;
  logic        stable_err = 1'b0;
  int          hold_cnt = 0;
  logic [21:0] cap_addr = '0;
  logic [31:0] cap_data = '0;
  logic [21:0] last_done_addr = '0;

  frame_writer #(
    .FRAME_WORDS(4),
    .BASE_ADDR  (22'd0),
    .FIFO_DEPTH (8),
    .CMD_NOP    (2'd0),
    .CMD_WRITE  (2'd2)
  ) dut (
    .i_Clk            (clk),
    .i_Rst_N          (rst_n),
    .i_Begin          (begin_en),
    .i_Pixel          (pix),
    .i_Pixel_Valid    (pix_valid),
    .i_Frame_Start    (frame_start),
    .o_Pixel_Ready    (ready),
    .i_Data_Write_Done(done),
    .o_Command        (cmd),
    .o_Data_Address   (addr),
    .o_Data_Write     (wdata),
    .o_Frame_Done     (frame_done),
    .o_Busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic exp_push(input logic [21:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic send_pixel(input logic [7:0] p, input logic fs);
    int t;
    @(negedge clk);
    pix = p;
    pix_valid = 1'b1;
    frame_start = fs;
    t = 0;
    while (!ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) begin
      check("ready_timeout", ready, 1);
      pix_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    frame_start = 1'b0;
    sent++;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy || cmd != CMD_NOP) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain", (exp_q.size() == 0) && !busy, 1);
    repeat (3) @(negedge clk);
  endtask

  // Controller responder and output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    done = 1'b0;
    if (!rst_n) begin
      active = 1'b0;
      done_sent = 1'b0;
    end else if (done_sent) begin
      check("nop_after_done", cmd, CMD_NOP);
      done_sent = 1'b0;
      active = 1'b0;
    end else if (cmd == CMD_WRITE) begin
      if (!active) begin
        active = 1'b1;
        hold_cnt = 0;
        stable_err = 1'b0;
        cap_addr = addr;
        cap_data = wdata;
        check("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("write", {addr, wdata}, exp_q.pop_front());
      end else if (addr != cap_addr || wdata != cap_data) begin
        stable_err = 1'b1;
      end
      hold_cnt++;
      if (done_en && hold_cnt >= done_delay) begin
        done = 1'b1;
        done_sent = 1'b1;
        last_done_addr = cap_addr;
        check("hold_stable", stable_err, 0);
      end
    end else if (active) begin
      check("cmd_held", cmd, CMD_WRITE);
      active = 1'b0;
    end
    if (frame_done) begin
      fd_cnt++;
      check("frame_done_addr", last_done_addr, 22'd3);
    end
  end

  initial begin
    int fd_base;
    int sent_base;
    int t;
    logic [7:0] b [4];

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_cmd", cmd, CMD_NOP);
    check("rst_addr", addr, 22'd0);
    check("rst_data", wdata, 32'd0);
    check("rst_ready", ready, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    begin_en = 1'b1;
    repeat (3) @(negedge clk);
    check("ready_after_begin", ready, 1);

    // Single word with frame start
    fd_base = fd_cnt;
    done_delay = 3;
    exp_push(22'd0, 32'h44332211);
    send_pixel(8'h11, 1'b1);
    send_pixel(8'h22, 1'b0);
    send_pixel(8'h33, 1'b0);
    send_pixel(8'h44, 1'b0);
    wait_drain();

    // Two words, slow controller
    done_delay = 5;
    exp_push(22'd0, 32'h04030201);
    exp_push(22'd1, 32'h08070605);
    for (int i = 1; i <= 8; i++) send_pixel(8'(i), i == 1);
    wait_drain();
    check("frame_done_none", fd_cnt - fd_base, 0);

    // Backpressure: Done withheld until the buffer fills
    fd_base = fd_cnt;
    done_delay = 2;
    done_en = 1'b0;
    sent_base = sent;
    for (int j = 0; j < 10; j++)
      exp_push(22'(j % 4), {8'(8'h43 + 4*j), 8'(8'h42 + 4*j), 8'(8'h41 + 4*j), 8'(8'h40 + 4*j)});
    fork
      begin
        for (int i = 0; i < 40; i++) send_pixel(8'(8'h40 + i), i == 0);
      end
      begin
        t = 0;
        @(negedge clk);
        while (ready && t < 500) begin
          @(negedge clk);
          t++;
        end
        check("ready_fell", ready, 0);
        check("accepted_when_full", sent - sent_base, 36);
        repeat (10) @(negedge clk);
        check("ready_still_low", ready, 0);
        check("no_accept_while_full", sent - sent_base, 36);
        done_en = 1'b1;
      end
    join
    wait_drain();
    check("accepted_total", sent - sent_base, 40);
    check("frame_done_backpressure", fd_cnt - fd_base, 2);

    // Frame wrap: 20 pixels -> addresses 0,1,2,3,0
    fd_base = fd_cnt;
    for (int j = 0; j < 5; j++)
      exp_push(22'(j % 4), {8'(8'hC3 + 4*j), 8'(8'hC2 + 4*j), 8'(8'hC1 + 4*j), 8'(8'hC0 + 4*j)});
    for (int i = 0; i < 20; i++) send_pixel(8'(8'hC0 + i), i == 0);
    wait_drain();
    check("frame_done_once", fd_cnt - fd_base, 1);

    // Partial word discarded by a frame start
    exp_push(22'd0, 32'hDDCCBBAA);
    send_pixel(8'h55, 1'b0);
    send_pixel(8'h66, 1'b0);
    send_pixel(8'hAA, 1'b1);
    send_pixel(8'hBB, 1'b0);
    send_pixel(8'hCC, 1'b0);
    send_pixel(8'hDD, 1'b0);
    wait_drain();

    // Reset during a write: first word in flight, second buffered, 2 bytes packed
    done_en = 1'b0;
    exp_push(22'd1, 32'h74737271);
    for (int i = 1; i <= 10; i++) send_pixel(8'(8'h70 + i), 1'b0);
    t = 0;
    while (cmd != CMD_WRITE && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("write_before_reset", cmd, CMD_WRITE);
    #2 rst_n = 1'b0;
    #1;
    check("async_nop", cmd, CMD_NOP);
    check("async_addr", addr, 22'd0);
    check("async_ready", ready, 0);
    check("async_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_en = 1'b1;
    @(negedge clk);
    check("post_reset_busy", busy, 0);
    check("post_reset_queue", exp_q.size(), 0);
    b[0] = 8'hE1; b[1] = 8'hE2; b[2] = 8'hE3; b[3] = 8'hE4;
    exp_push(22'd0, {b[3], b[2], b[1], b[0]});
    for (int i = 0; i < 4; i++) send_pixel(b[i], 1'b0);
    wait_drain();
    repeat (20) @(negedge clk);
    check("no_stale_writes", (cmd == CMD_NOP) && !busy, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
